// File: rtl/mem_stage_pkg.sv
// Shared opcode constants and state encoding for the memory stage.
package mem_stage_pkg;

  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage: decodes lw/sw, runs a req/ack data-memory access with timeout,
// stalls the pipeline while busy and registers the MEM/WB beat.
//
// state | meaning
// IDLE  | accepting instructions; non-memory ops pass straight to WB
// RD    | load outstanding, waiting for dmem_ack or timeout
// WR    | store outstanding, waiting for dmem_ack or timeout
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [REG_W-1:0]  rd,
  output logic              dmem_req,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [REG_W-1:0] rd_q;
  logic [TO_W-1:0]  to_cnt;
  logic             accept_mem;
  logic             busy;
  logic             to_hit;

  assign busy       = (state != IDLE);
  assign accept_mem = (state == IDLE) && in_valid && in_ready &&
                      ((opcode == OP_LW) || (opcode == OP_SW));
  // to_cnt counts earlier ack-less cycles, so TIMEOUT-1 marks the last allowed one
  assign to_hit     = busy && !dmem_ack && (to_cnt == TO_W'(TIMEOUT - 1));

  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (accept_mem),
    .inc     (busy && !dmem_ack),
    .count   (to_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (!in_ready),
    .count   (stall_cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_wren  <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      err        <= 1'b0;
      rd_q       <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (opcode == OP_LW) begin
              state     <= RD;
              in_ready  <= 1'b0;
              dmem_req  <= 1'b1;
              dmem_wren <= 1'b0;
              dmem_addr <= alu_result[ADDR_W-1:0];
              rd_q      <= rd;
            end else if (opcode == OP_SW) begin
              state      <= WR;
              in_ready   <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_wren  <= 1'b1;
              dmem_addr  <= alu_result[ADDR_W-1:0];
              dmem_wdata <= operand_b;
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= alu_result;
              wb_rd    <= rd;
            end
          end
        end
        RD, WR: begin
          if (dmem_ack || to_hit) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            dmem_req  <= 1'b0;
            dmem_wren <= 1'b0;
          end
          // ack takes priority over a timeout landing in the same cycle
          if (dmem_ack) begin
            if (state == RD) begin
              wb_valid <= 1'b1;
              wb_data  <= dmem_rdata;
              wb_rd    <= rd_q;
            end
          end else if (to_hit) begin
            err <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
